// File: rtl/dct2_transpose_buf.sv
// dct2_transpose_buf
// Ping-pong transpose memory between the row and column passes of the 2D
// DCT-II. Rows of an LxL block (L = 4/8/16/32) are written into one bank
// while the other bank is read out column by column. Each bank tracks its
// own EMPTY/FILLING/FULL/DRAINING state and the block size it holds.
module dct2_transpose_buf #(
    parameter int W    = 16,
    parameter int NMAX = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NMAX*W-1:0] in_row,
    input  logic [1:0]        in_size,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NMAX*W-1:0] out_col,
    output logic [1:0]        out_size,
    output logic              out_last
);

    typedef enum logic [1:0] {
        B_EMPTY    = 2'b00,
        B_FILLING  = 2'b01,
        B_FULL     = 2'b10,
        B_DRAINING = 2'b11
    } bank_state_e;

    bank_state_e state_q [2];
    bank_state_e state_d [2];
    logic [1:0]  size_q  [2];
    logic [1:0]  size_d  [2];
    logic        wr_bank_q, wr_bank_d;
    logic        rd_bank_q, rd_bank_d;
    logic [4:0]  wr_row_q, wr_row_d;
    logic [4:0]  rd_col_q, rd_col_d;

    // Block storage; contents are never reset, only the bookkeeping is.
    logic [W-1:0] mem_q [2][NMAX][NMAX];

    logic       in_xfer_s;
    logic       out_xfer_s;
    logic       out_valid_s;
    logic [1:0] wr_size_s;
    logic [4:0] wr_last_s;
    logic [4:0] rd_last_s;

    // Index of the last row/column for a size code (L-1).
    function automatic logic [4:0] last_idx(input logic [1:0] code);
        case (code)
            2'b00:   return 5'd3;
            2'b01:   return 5'd7;
            2'b10:   return 5'd15;
            2'b11:   return 5'd31;
            default: return 5'd31;
        endcase
    endfunction

    // Handshake qualifiers and the size in effect for the write and read sides.
    always_comb begin
        out_valid_s = (state_q[rd_bank_q] == B_FULL) || (state_q[rd_bank_q] == B_DRAINING);
        in_ready    = rst_n && ((state_q[wr_bank_q] == B_EMPTY) || (state_q[wr_bank_q] == B_FILLING));
        in_xfer_s   = in_valid && in_ready;
        out_xfer_s  = out_valid_s && out_ready;
        // Row 0 of a block takes its size from the port; later rows use the stored size.
        if (state_q[wr_bank_q] == B_EMPTY) begin
            wr_size_s = in_size;
        end else begin
            wr_size_s = size_q[wr_bank_q];
        end
        wr_last_s = last_idx(wr_size_s);
        rd_last_s = last_idx(size_q[rd_bank_q]);
    end

    // Next-state logic for bank states, sizes, bank pointers and counters.
    // The write and read sides always act on different banks, so their
    // updates never collide.
    always_comb begin
        state_d   = state_q;
        size_d    = size_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_row_d  = wr_row_q;
        rd_col_d  = rd_col_q;

        if (in_xfer_s) begin
            size_d[wr_bank_q]  = wr_size_s;
            state_d[wr_bank_q] = B_FILLING;
            if (wr_row_q == wr_last_s) begin
                state_d[wr_bank_q] = B_FULL;
                wr_row_d           = 5'd0;
                wr_bank_d          = ~wr_bank_q;
            end else begin
                wr_row_d = wr_row_q + 5'd1;
            end
        end else begin
            wr_row_d = wr_row_q;
        end

        if (out_xfer_s) begin
            state_d[rd_bank_q] = B_DRAINING;
            if (rd_col_q == rd_last_s) begin
                state_d[rd_bank_q] = B_EMPTY;
                rd_col_d           = 5'd0;
                rd_bank_d          = ~rd_bank_q;
            end else begin
                rd_col_d = rd_col_q + 5'd1;
            end
        end else begin
            rd_col_d = rd_col_q;
        end
    end

    // Bookkeeping registers; reset discards any partial or pending block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= B_EMPTY;
                size_q[b]  <= 2'b00;
            end
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_row_q  <= 5'd0;
            rd_col_q  <= 5'd0;
        end else begin
            state_q   <= state_d;
            size_q    <= size_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_row_q  <= wr_row_d;
            rd_col_q  <= rd_col_d;
        end
    end

    // Store elements 0..L-1 of an accepted row; the rest of the row is dropped.
    always_ff @(posedge clk) begin
        if (in_xfer_s) begin
            for (int c = 0; c < NMAX; c++) begin
                if (5'(c) <= wr_last_s) begin
                    mem_q[wr_bank_q][wr_row_q][c] <= in_row[W*c +: W];
                end
            end
        end
    end

    // Column read-out: element r is stored row r at the current column,
    // zero beyond L and everything zero while no column is offered.
    always_comb begin
        out_col   = '0;
        out_valid = out_valid_s;
        for (int r = 0; r < NMAX; r++) begin
            if (out_valid_s && (5'(r) <= rd_last_s)) begin
                out_col[W*r +: W] = mem_q[rd_bank_q][r][rd_col_q];
            end else begin
                out_col[W*r +: W] = '0;
            end
        end
        if (out_valid_s) begin
            out_size = size_q[rd_bank_q];
            out_last = (rd_col_q == rd_last_s);
        end else begin
            out_size = 2'b00;
            out_last = 1'b0;
        end
    end

endmodule

// File: tb/tb_dct2_transpose_buf.sv
// Self-checking bench for dct2_transpose_buf. A reference model keeps whole
// blocks in a queue (complete blocks awaiting/undergoing drain) and predicts
// readiness, validity and every column purely from block occupancy.
module tb_dct2_transpose_buf;
    localparam int W    = 16;
    localparam int NMAX = 32;
    localparam int CW   = NMAX * W;
    localparam int BW   = NMAX * NMAX * W;

    localparam int M_RAND = 0;
    localparam int M_PAT  = 1;
    localparam int M_CORN = 2;
    localparam int M_TOGG = 3;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_row    = '0;
    logic [1:0]    in_size   = 2'b00;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_col;
    logic [1:0]    out_size;
    logic          out_last;

    dct2_transpose_buf #(.W(W), .NMAX(NMAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .in_size   (in_size),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_col   (out_col),
        .out_size  (out_size),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int checks_n = 0;
    int errors_n = 0;

    // Reference model state
    logic [BW-1:0] blk_q[$];
    logic [1:0]    sz_q[$];
    logic [BW-1:0] cur_blk = '0;
    logic [1:0]    cur_sz  = 2'b00;
    int            cur_rows = 0;
    int            rd_c     = 0;

    function automatic int len(input logic [1:0] s);
        return 4 << s;
    endfunction

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks_n++;
        assert (obs === exp) else begin
            errors_n++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [CW-1:0] ecol;
        logic          ev, el, er;
        logic [1:0]    es;
        ecol = '0;
        es   = 2'b00;
        el   = 1'b0;
        er   = rst_n && (blk_q.size() < 2);
        ev   = rst_n && (blk_q.size() > 0);
        if (ev) begin
            es = sz_q[0];
            for (int r = 0; r < len(es); r++) begin
                ecol[W*r +: W] = blk_q[0][(r*NMAX + rd_c)*W +: W];
            end
            el = (rd_c == len(es) - 1);
        end
        check("in_ready",  CW'(in_ready),  CW'(er));
        check("out_valid", CW'(out_valid), CW'(ev));
        check("out_size",  CW'(out_size),  CW'(es));
        check("out_last",  CW'(out_last),  CW'(el));
        check("out_col",   out_col,        ecol);
    endtask

    function automatic logic [CW-1:0] make_row(input int mode, input int r);
        logic [CW-1:0] row;
        for (int c = 0; c < NMAX; c++) begin
            if (mode == M_PAT) row[W*c +: W] = 16'(16*r + c);
            else               row[W*c +: W] = 16'($urandom);
        end
        if (mode == M_CORN && (r == 0 || r == NMAX-1)) begin
            row[0 +: W]          = (r == 0) ? 16'h8000 : 16'hFFFF;
            row[W*(NMAX-1) +: W] = (r == 0) ? 16'hFFFF : 16'h8000;
        end
        return row;
    endfunction

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input logic iv, input logic [CW-1:0] row, input logic [1:0] sz,
                         input logic ordy, output logic acc);
        logic in_x, out_x;
        in_valid  = iv;
        in_row    = row;
        in_size   = sz;
        out_ready = ordy;
        #1;
        check_outputs();
        in_x  = iv && rst_n && (blk_q.size() < 2);
        out_x = ordy && (blk_q.size() > 0);
        acc   = in_x;
        @(posedge clk);
        if (out_x) begin
            rd_c++;
            if (rd_c == len(sz_q[0])) begin
                void'(blk_q.pop_front());
                void'(sz_q.pop_front());
                rd_c = 0;
            end
        end
        if (in_x) begin
            if (cur_rows == 0) begin
                cur_blk = '0;
                cur_sz  = sz;
            end
            for (int c = 0; c < len(cur_sz); c++) begin
                cur_blk[(cur_rows*NMAX + c)*W +: W] = row[W*c +: W];
            end
            cur_rows++;
            if (cur_rows == len(cur_sz)) begin
                blk_q.push_back(cur_blk);
                sz_q.push_back(cur_sz);
                cur_rows = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic send_rows(input logic [1:0] sz, input int n, input int mode, input logic ordy);
        logic acc;
        int   r     = 0;
        int   guard = 0;
        logic [1:0] s;
        while (r < n) begin
            s = (r == 0 || mode != M_TOGG) ? sz : ~sz;
            cycle(1'b1, make_row(mode, r), s, ordy, acc);
            if (acc) r++;
            guard++;
            if (guard > 2000) begin
                errors_n++;
                $error("FAIL send_timeout observed=%0d rows expected=%0d rows", r, n);
                break;
            end
        end
    endtask

    task automatic idle(input int n, input logic ordy, input logic iv);
        logic acc;
        for (int i = 0; i < n; i++) begin
            cycle(iv, make_row(M_RAND, i), 2'($urandom), ordy, acc);
        end
    endtask

    task automatic do_reset(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        blk_q.delete();
        sz_q.delete();
        cur_rows = 0;
        rd_c     = 0;
        check_outputs();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_outputs();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        logic acc;
        @(negedge clk);
        do_reset(3);

        // Size 4 with patterned rows, consumer always ready
        send_rows(2'b00, 4, M_PAT, 1'b1);
        idle(8, 1'b1, 1'b0);

        // Two back-to-back size-32 blocks
        send_rows(2'b11, 32, M_RAND, 1'b1);
        send_rows(2'b11, 32, M_RAND, 1'b1);
        idle(70, 1'b1, 1'b0);

        // Size 8: fill both banks with the consumer stalled, keep offering rows
        send_rows(2'b01, 16, M_RAND, 1'b0);
        idle(20, 1'b0, 1'b1);
        idle(24, 1'b1, 1'b0);

        // Sizes 16 then 4 with in_size flipped on the later rows
        send_rows(2'b10, 16, M_TOGG, 1'b1);
        send_rows(2'b00, 4, M_TOGG, 1'b1);
        idle(24, 1'b1, 1'b0);

        // Extreme bit patterns at the corners of a size-32 block
        send_rows(2'b11, 32, M_CORN, 1'b1);
        idle(36, 1'b1, 1'b0);

        // Reset part way through filling a size-16 block
        send_rows(2'b10, 5, M_RAND, 1'b1);
        do_reset(2);
        idle(4, 1'b1, 1'b0);

        // Reset part way through draining a size-8 block
        send_rows(2'b01, 8, M_RAND, 1'b0);
        idle(3, 1'b1, 1'b0);
        do_reset(2);
        idle(4, 1'b1, 1'b0);
        send_rows(2'b10, 16, M_RAND, 1'b1);
        idle(20, 1'b1, 1'b0);

        // Random traffic on both sides with random sizes
        for (int i = 0; i < 800; i++) begin
            cycle(1'($urandom), make_row(M_RAND, i), 2'($urandom),
                  ($urandom_range(0, 3) != 0), acc);
        end
        idle(80, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks_n, errors_n);
        $finish;
    end

endmodule

// File: doc/dct2_transpose_buf.md
# dct2_transpose_buf

Ping-pong transpose memory between the first (row) and second (column) 1D DCT-II passes of the 2D forward transform. Accepts one 16-bit-per-coefficient row per cycle from the row-pass `dct2_1d` output, stores a full LxL block (L = 4, 8, 16 or 32), and emits the same block column by column for the column pass. Two banks let one block fill while the previous one drains, giving full throughput with no bubbles.

## Interface
Parameters
- `W`, 16, coefficient width in bits
- `NMAX`, 32, maximum block dimension; the bank is NMAX x NMAX x W

Ports
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset; asynchronous assert, active-low
- `in_valid`  in  1  a row is presented on `in_row`
- `in_ready`  out  1  buffer accepts `in_row` this cycle
- `in_row`  in  NMAX*W  row coefficients; element i is `in_row[W*i +: W]`, signed
- `in_size`  in  2  block size code: 00=4, 01=8, 10=16, 11=32; same encoding as `N` in the 1D stage
- `out_valid`  out  1  a column is presented on `out_col`
- `out_ready`  in  1  consumer takes `out_col` this cycle
- `out_col`  out  NMAX*W  column coefficients; element r is `out_col[W*r +: W]`
- `out_size`  out  2  size code of the block being drained
- `out_last`  out  1  `out_col` is the final column (c = L-1) of its block

## Operation
- Transfer rules: input transfer when `in_valid && in_ready`; output transfer when `out_valid && out_ready`. `in_row` may change freely while `in_valid` is low.
- Each bank has its own 2-bit state: EMPTY -> FILLING (first row accepted) -> FULL (row L-1 accepted) -> DRAINING (first column taken) -> EMPTY (column L-1 taken). A size-4 block can go FILLING->FULL and DRAINING->EMPTY with no intermediate cycles beyond the L transfers.
- `wr_bank` selects the bank being filled; `rd_bank` selects the bank being drained. Both reset to bank 0. Each toggles after its bank completes (row L-1 written / column L-1 read).
- `in_ready` = `rst_n` and bank[`wr_bank`] is EMPTY or FILLING. Driven from registered state only; no same-cycle bypass from an output transfer.
- `in_size` is sampled on the first row of a block (row 0) and stored per bank; changes on rows 1..L-1 are ignored.
- Write: row r of the block stores elements 0..L-1 into bank[`wr_bank`][r][0..L-1]; elements L..NMAX-1 of `in_row` are discarded.
- Read: `out_col` element r = stored row r, element c, for r < L; elements r >= L are driven 0. `out_size` = the stored size of bank[`rd_bank`].
- `out_valid` = bank[`rd_bank`] is FULL or DRAINING. `out_last` = `out_valid` and c = L-1.
- When `out_valid` is low, `out_col`, `out_size` and `out_last` are all 0.
- Row counter `wr_row` and column counter `rd_col` are 5 bits each, cleared when their block completes. Counters and states are the only reset state; bank contents are not reset.
- Values pass through unaltered: no rounding, saturation or width change (rounding already applied by the 1D stage's [26:11] selection).

## Timing
- Reset (`rst_n` low, asynchronous): both banks EMPTY, counters 0, `wr_bank` = `rd_bank` = 0; `in_ready` = 0, `out_valid` = 0, `out_col` = 0, `out_size` = 0, `out_last` = 0. `in_ready` rises in the first cycle after `rst_n` deasserts.
- Latency: if row L-1 is accepted at edge k, `out_valid` is high for the cycle after edge k, with column 0 present.
- Throughput: 1 row/cycle in, 1 column/cycle out; with both sides always valid/ready, steady state is L input and L output transfers every L cycles.
- Both banks full: `in_ready` low until the draining bank's last column transfers; `in_ready` rises the cycle after that edge.
- Simultaneous input and output transfers on different banks in the same cycle are legal and independent.
- `out_valid` is never deasserted while stalled (`out_ready` low); `out_col` is held stable until transfer.
- Reset mid-block: the partial block and any pending block are discarded; no column of them appears after reset.

## Test plan
- Size 4 (`in_size`=00), rows r with element c = 16*r+c, `out_ready`=1 -> 4 columns, column c element r = 16*r+c, rows 4..31 zero, `out_last` only on c=3, `out_valid` first high one cycle after the 4th row.
- Size 32, back-to-back blocks A then B, both sides always ready -> `in_ready` never drops, 64 output columns with no gaps, B's data never mixes with A's.
- Size 8 with `out_ready`=0 for 20 cycles after 2 blocks filled -> `in_ready` low after the 16th row, `out_col` stable; on release, `in_ready` rises one cycle after the 8th column of the first block transfers.
- Alternating sizes 16 then 4, `in_size` toggled on rows 1..L-1 -> `out_size` = 10 then 00, each block transposed at its own size.
- Negative values (0x8000, 0xFFFF) at corners of a size-32 block -> same bit patterns appear transposed, no sign or width change.
- `rst_n` pulsed low mid-fill (row 5 of a size-16 block) and mid-drain -> all outputs 0 during reset, no stale column afterwards, next full block transposes correctly.
